// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, RAM access
// size, PC step and the fetch state encoding.
package ifu_pkg;

  localparam logic [63:0] PC_START_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [2:0]  RAM_SIZE_WORD    = 3'b010;
  localparam int          PC_INC           = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch queue of {pc, instr} pairs. The head is registered so decode never
// sees a combinational path from the RAM data bus. Pointers carry one extra
// bit so that full and empty can be told apart.
module ifu_fifo #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_pc,
  input  logic [INSTR_W-1:0]      push_instr,
  input  logic                    pop,
  output logic [ADDR_W-1:0]       head_pc,
  output logic [INSTR_W-1:0]      head_instr,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);

  logic [ADDR_W-1:0]  mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [PTR_W-1:0]   count_next;
  logic               do_push;
  logic               do_pop;
  logic [ADDR_W-1:0]  next_head_pc;
  logic [INSTR_W-1:0] next_head_instr;

  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & (count != FULL);
  assign do_pop  = pop & (count != '0);

  // Work out the pointers after this edge and which entry becomes the head;
  // a push into an empty (or just-emptied) queue bypasses the storage.
  always_comb begin
    wr_ptr_next     = wr_ptr + (do_push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_next     = rd_ptr + (do_pop ? PTR_W'(1) : PTR_W'(0));
    count_next      = wr_ptr_next - rd_ptr_next;
    next_head_pc    = mem_pc[rd_ptr_next[IDX_W-1:0]];
    next_head_instr = mem_instr[rd_ptr_next[IDX_W-1:0]];
    if (do_push && (rd_ptr_next == wr_ptr)) begin
      next_head_pc    = push_pc;
      next_head_instr = push_instr;
    end
  end

  // Entry storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem_pc[wr_ptr[IDX_W-1:0]]    <= push_pc;
      mem_instr[wr_ptr[IDX_W-1:0]] <= push_instr;
    end
  end

  // Read/write pointers; clear empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
    end
  end

  // Registered head; it keeps its last value while the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_pc    <= '0;
      head_instr <= '0;
    end else if (!clear && (count_next != '0)) begin
      head_pc    <= next_head_pc;
      head_instr <= next_head_instr;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: keeps a small prefetch queue topped up from the
// instruction RAM and restarts cleanly at a new PC on interrupt or branch.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] PC_START = ADDR_W'(PC_START_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  o_ram_addr,
  output logic               o_ram_valid,
  input  logic               i_ram_ready,
  input  logic [INSTR_W-1:0] i_ram_rdata,
  output logic [2:0]         o_ram_size,
  input  logic               i_hold,
  input  logic               i_branch_jump,
  input  logic [ADDR_W-1:0]  i_next_pc,
  input  logic               i_int_valid,
  input  logic [ADDR_W-1:0]  i_int_addr,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_instr_valid,
  output logic               o_flushing
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_INC);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic [ADDR_W-1:0] fetch_pc_inc;
  logic [ADDR_W-1:0] ram_addr_next;
  logic [ADDR_W-1:0] target;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic              redirect;
  logic              pop;
  logic              push;

  assign redirect      = i_int_valid | i_branch_jump;
  assign target        = i_int_valid ? i_int_addr : i_next_pc;
  assign o_instr_valid = (count != '0);
  assign pop           = o_instr_valid & ~i_hold & ~redirect;
  assign push          = (state == REQ) & i_ram_ready & ~redirect;
  assign fetch_pc_inc  = fetch_pc + PC_STEP;
  assign count_after   = count + CNT_W'(1) - (pop ? CNT_W'(1) : CNT_W'(0));
  assign o_ram_valid   = (state != IDLE);
  assign o_flushing    = (state == DROP);
  assign o_ram_size    = RAM_SIZE_WORD;

  ifu_fifo #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (redirect),
    .push       (push),
    .push_pc    (o_ram_addr),
    .push_instr (i_ram_rdata),
    .pop        (pop),
    .head_pc    (o_pc),
    .head_instr (o_instr),
    .count      (count)
  );

  // Fetch sequencing: issue only with queue credit, drain a stale request
  // that cannot be withdrawn, and restart at the redirect target.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    ram_addr_next = o_ram_addr;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = target;
          ram_addr_next = target;
          state_next    = REQ;
        end else if (count < DEPTH_CNT) begin
          ram_addr_next = fetch_pc;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_next = target;
          if (i_ram_ready) begin
            ram_addr_next = target;
          end else begin
            state_next = DROP;
          end
        end else if (i_ram_ready) begin
          fetch_pc_next = fetch_pc_inc;
          if (count_after < DEPTH_CNT) begin
            ram_addr_next = fetch_pc_inc;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          fetch_pc_next = target;
        end else if (i_ram_ready) begin
          ram_addr_next = fetch_pc;
          state_next    = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, fetch PC and the held RAM address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_pc   <= PC_START;
      o_ram_addr <= PC_START;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      o_ram_addr <= ram_addr_next;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed scenarios plus random
// hold/ready/redirect traffic, compared against a queue-based model of the
// instruction stream decode should see.
module tb_ifu_prefetch;

  localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 4;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] o_ram_addr;
  logic        o_ram_valid;
  logic        i_ram_ready;
  logic [31:0] i_ram_rdata;
  logic [2:0]  o_ram_size;
  logic        i_hold;
  logic        i_branch_jump;
  logic [63:0] i_next_pc;
  logic        i_int_valid;
  logic [63:0] i_int_addr;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic        o_instr_valid;
  logic        o_flushing;

  int compared   = 0;
  int mismatched = 0;

  // Model of the architectural fetch stream.
  entry_t      mq[$];
  logic [63:0] exp_fetch;
  bit          stale;
  bit          prev_pending;
  logic [63:0] prev_addr;
  bit          prev_should_issue;
  int          consumed;
  int          fetched;
  bit          checks_on = 0;

  logic        r_rst, r_hold, r_ready, r_redir, r_int, r_br;
  logic [63:0] r_npc, r_iaddr;

  ifu_prefetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_ram_addr    (o_ram_addr),
    .o_ram_valid   (o_ram_valid),
    .i_ram_ready   (i_ram_ready),
    .i_ram_rdata   (i_ram_rdata),
    .o_ram_size    (o_ram_size),
    .i_hold        (i_hold),
    .i_branch_jump (i_branch_jump),
    .i_next_pc     (i_next_pc),
    .i_int_valid   (i_int_valid),
    .i_int_addr    (i_int_addr),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_instr_valid (o_instr_valid),
    .o_flushing    (o_flushing)
  );

  always #5 clk = ~clk;

  // Instruction RAM contents are a fixed function of the address.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  assign i_ram_rdata = instr_of(o_ram_addr);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    exp_fetch         = PC_START;
    stale             = 0;
    prev_pending      = 0;
    prev_should_issue = 0;
    consumed          = 0;
    fetched           = 0;
  endtask

  // Advance the model across the coming edge using the current outputs.
  task automatic modelEdge(input logic rst, input logic hold, input logic br, input logic [63:0] npc,
                           input logic iv, input logic [63:0] iaddr, input logic ready);
    logic redirect;
    redirect = iv | br;
    if (!rst) begin
      modelReset();
      return;
    end
    prev_should_issue = !o_ram_valid && ((mq.size() < DEPTH) || redirect);
    prev_pending      = o_ram_valid && !ready;
    prev_addr         = o_ram_addr;
    if (redirect) begin
      mq.delete();
      exp_fetch = iv ? iaddr : npc;
      if (o_ram_valid && !ready) stale = 1;
    end else begin
      if (!hold && mq.size() > 0) begin
        void'(mq.pop_front());
        consumed++;
      end
      if (o_ram_valid && ready) begin
        if (stale) begin
          stale = 0;
        end else begin
          mq.push_back('{pc: exp_fetch, instr: instr_of(exp_fetch)});
          fetched++;
          exp_fetch = exp_fetch + 64'd4;
          checkOutput("queue_overflow", 64'(mq.size() <= DEPTH), 64'd1);
        end
      end
    end
  endtask

  // Compare the DUT's visible state against the model after an edge.
  task automatic checkCycle();
    checkOutput("instr_valid", 64'(o_instr_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkOutput("head_pc", o_pc, mq[0].pc);
      checkOutput("head_instr", 64'(o_instr), 64'(mq[0].instr));
    end
    checkOutput("flushing", 64'(o_flushing), 64'(stale));
    checkOutput("ram_size", 64'(o_ram_size), 64'd2);
    if (prev_pending) begin
      checkOutput("ram_valid_held", 64'(o_ram_valid), 64'd1);
      checkOutput("ram_addr_held", o_ram_addr, prev_addr);
    end
    if (prev_should_issue) checkOutput("issue_with_credit", 64'(o_ram_valid), 64'd1);
    if (o_ram_valid && !stale) begin
      checkOutput("fetch_addr", o_ram_addr, exp_fetch);
      checkOutput("issue_credit", 64'(mq.size() < DEPTH), 64'd1);
    end
  endtask

  // Drive one cycle of inputs, step the model, cross the edge and check.
  task automatic applyStimulus(input logic rst, input logic hold, input logic br, input logic [63:0] npc,
                               input logic iv, input logic [63:0] iaddr, input logic ready);
    rst_n         = rst;
    i_hold        = hold;
    i_branch_jump = br;
    i_next_pc     = npc;
    i_int_valid   = iv;
    i_int_addr    = iaddr;
    i_ram_ready   = ready;
    modelEdge(rst, hold, br, npc, iv, iaddr, ready);
    @(negedge clk);
    if (checks_on) checkCycle();
  endtask

  task automatic runStep(input logic hold, input logic ready);
    applyStimulus(1'b1, hold, 1'b0, 64'd0, 1'b0, 64'd0, ready);
  endtask

  task automatic resetStep();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
  endtask

  task automatic waitPending();
    for (int k = 0; k < 8 && !o_ram_valid; k++) runStep(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; i_hold = 1'b0; i_branch_jump = 1'b0; i_next_pc = '0;
    i_int_valid = 1'b0; i_int_addr = '0; i_ram_ready = 1'b0;
    modelReset();
    @(negedge clk);
    resetStep();
    resetStep();
    checks_on = 1;

    // Reset state
    checkOutput("rst_ram_valid", 64'(o_ram_valid), 64'd0);
    checkOutput("rst_ram_addr", o_ram_addr, PC_START);
    checkOutput("rst_instr_valid", 64'(o_instr_valid), 64'd0);
    checkOutput("rst_pc", o_pc, 64'd0);
    checkOutput("rst_instr", 64'(o_instr), 64'd0);
    checkOutput("rst_flushing", 64'(o_flushing), 64'd0);

    // Zero-wait streaming: first instruction after two edges, then one per cycle
    $display("[TB] streaming");
    runStep(1'b0, 1'b1);
    runStep(1'b0, 1'b1);
    checkOutput("t1_first_valid", 64'(o_instr_valid), 64'd1);
    checkOutput("t1_first_pc", o_pc, PC_START);
    for (int i = 0; i < 10; i++) runStep(1'b0, 1'b1);
    checkOutput("t1_rate", 64'(consumed), 64'd10);

    // Hold fills the queue to DEPTH and stops fetching
    $display("[TB] hold");
    resetStep();
    for (int i = 0; i < 10; i++) runStep(1'b1, 1'b1);
    checkOutput("t2_fetched", 64'(fetched), 64'(DEPTH));
    checkOutput("t2_ram_idle", 64'(o_ram_valid), 64'd0);
    runStep(1'b0, 1'b1);
    runStep(1'b0, 1'b1);
    checkOutput("t2_resume_valid", 64'(o_ram_valid), 64'd1);
    checkOutput("t2_resume_addr", o_ram_addr, PC_START + 64'h10);
    for (int i = 0; i < 6; i++) runStep(1'b0, 1'b1);

    // Branch while a request is stalled: drain it, then fetch the target
    $display("[TB] branch during stall");
    waitPending();
    checkOutput("t3_pending", 64'(o_ram_valid), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'd0, 1'b0);
    runStep(1'b0, 1'b0);
    runStep(1'b0, 1'b0);
    checkOutput("t3_flushing", 64'(o_flushing), 64'd1);
    runStep(1'b0, 1'b1);
    checkOutput("t3_target_addr", o_ram_addr, 64'h8000_0100);
    runStep(1'b0, 1'b1);
    checkOutput("t3_first_pc", o_pc, 64'h8000_0100);

    // Interrupt wins over a simultaneous branch
    $display("[TB] interrupt priority");
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h8000_0100, 1'b1, 64'h8000_0200, 1'b1);
    checkOutput("t4_fetch_addr", o_ram_addr, 64'h8000_0200);
    runStep(1'b0, 1'b1);
    checkOutput("t4_first_pc", o_pc, 64'h8000_0200);

    // PC wraps from the top of the address space to zero
    $display("[TB] pc wrap");
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0, 1'b1);
    runStep(1'b0, 1'b1);
    runStep(1'b0, 1'b1);
    checkOutput("t5_wrap_pc", o_pc, 64'd0);
    checkOutput("t5_wrap_valid", 64'(o_instr_valid), 64'd1);

    // Reset in the middle of a pending request
    $display("[TB] reset mid-request");
    waitPending();
    checkOutput("t6_pending", 64'(o_ram_valid), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
    checkOutput("t6_ram_valid", 64'(o_ram_valid), 64'd0);
    checkOutput("t6_instr_valid", 64'(o_instr_valid), 64'd0);
    checkOutput("t6_ram_addr", o_ram_addr, PC_START);
    checkOutput("t6_pc", o_pc, 64'd0);
    runStep(1'b0, 1'b1);
    runStep(1'b0, 1'b1);
    checkOutput("t6_restart_pc", o_pc, PC_START);

    // Random hold/ready/redirect/reset traffic
    $display("[TB] random traffic");
    for (int c = 0; c < 2000; c++) begin
      r_rst   = ($urandom_range(999, 0) < 3) ? 1'b0 : 1'b1;
      r_hold  = ($urandom_range(99, 0) < 30);
      r_ready = ($urandom_range(99, 0) < 65);
      r_redir = !o_flushing && ($urandom_range(99, 0) < 6);
      r_int   = r_redir && ($urandom_range(1, 0) == 1);
      r_br    = r_redir && (!r_int || ($urandom_range(1, 0) == 1));
      r_npc   = {$urandom(), $urandom()} & ~64'h3;
      r_iaddr = {$urandom(), $urandom()} & ~64'h3;
      applyStimulus(r_rst, r_hold, r_br, r_npc, r_int, r_iaddr, r_ready);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
